// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the CPU control path.
//   ctrl_state_t   - sequencer state encoding (also shown on the state_poke debug port)
//   OP_*           - opcode constants; opcodes 0x8-0xF are undefined
//   ctrl_signals_t - bundle of the nine datapath control strobes
package cpu_pkg;

    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned WAIT_W   = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_EXEC     = 3'd3,
        ST_MEM_WAIT = 3'd4,
        ST_HALT     = 3'd5
    } ctrl_state_t;

    localparam logic [OPCODE_W-1:0] OP_ALU   = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_LDI   = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_LOAD  = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_STORE = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_JMP   = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_JZ    = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_INC   = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_HALT  = 4'h7;

    typedef struct packed {
        logic fetch_instruction;
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
        logic alu_override_imm;
        logic alu_override_b;
        logic alu_set_flags;
        logic set_pc;
        logic pc_from_register;
    } ctrl_signals_t;

    // Opcodes with the top bit set have no defined meaning.
    function automatic logic is_illegal(input logic [OPCODE_W-1:0] op);
        return op[OPCODE_W-1];
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: datapath <-> control sequencer signal bundle.
//   master (datapath side): drives run, current_instruction, Z_in (and step
//                           when CTRL_SINGLE_STEP_EN is defined); reads strobes/status.
//   slave  (sequencer side): the reverse.
//   Strobes: fetch_instruction, reg_write, mem_to_reg, mem_write, alu_override_imm,
//            alu_override_b, alu_set_flags, set_pc, pc_from_register.
//   Status:  halted, illegal_op, state_poke[2:0], retired[CNT_W-1:0].
interface control_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic                run;
    logic [15:0]         current_instruction;
    logic                Z_in;
`ifdef CTRL_SINGLE_STEP_EN
    logic                step;
`endif
    logic                fetch_instruction;
    logic                reg_write;
    logic                mem_to_reg;
    logic                mem_write;
    logic                alu_override_imm;
    logic                alu_override_b;
    logic                alu_set_flags;
    logic                set_pc;
    logic                pc_from_register;
    logic                halted;
    logic                illegal_op;
    logic [2:0]          state_poke;
    logic [CNT_W-1:0]    retired;

    modport master (
        output run, current_instruction, Z_in,
`ifdef CTRL_SINGLE_STEP_EN
        output step,
`endif
        input  fetch_instruction, reg_write, mem_to_reg, mem_write,
               alu_override_imm, alu_override_b, alu_set_flags, set_pc,
               pc_from_register, halted, illegal_op, state_poke, retired
    );

    modport slave (
        input  run, current_instruction, Z_in,
`ifdef CTRL_SINGLE_STEP_EN
        input  step,
`endif
        output fetch_instruction, reg_write, mem_to_reg, mem_write,
               alu_override_imm, alu_override_b, alu_set_flags, set_pc,
               pc_from_register, halted, illegal_op, state_poke, retired
    );
endinterface

// File: rtl/opcode_decoder.sv
// opcode_decoder: combinational map from (state, opcode, Z, last-wait) to strobes.
//   state_i     - current sequencer state
//   opcode_i    - instruction bits [15:12]
//   z_i         - datapath zero flag
//   last_wait_i - 1 on the final cycle of FETCH or MEM_WAIT
//   ctrl_o      - the nine datapath strobes
module opcode_decoder
    import cpu_pkg::*;
(
    input  ctrl_state_t                state_i,
    input  logic [OPCODE_W-1:0]        opcode_i,
    input  logic                       z_i,
    input  logic                       last_wait_i,
    output ctrl_signals_t              ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            ST_FETCH: begin
                ctrl_o.fetch_instruction = 1'b1;
                // PC advances on the same edge that the final capture happens.
                ctrl_o.set_pc            = last_wait_i;
            end
            ST_EXEC: begin
                unique case (opcode_i)
                    OP_ALU: begin
                        ctrl_o.reg_write     = 1'b1;
                        ctrl_o.alu_set_flags = 1'b1;
                    end
                    OP_LDI: begin
                        ctrl_o.reg_write        = 1'b1;
                        ctrl_o.alu_override_imm = 1'b1;
                    end
                    OP_STORE: ctrl_o.mem_write = 1'b1;
                    OP_JMP: begin
                        ctrl_o.set_pc           = 1'b1;
                        ctrl_o.pc_from_register = 1'b1;
                    end
                    OP_JZ: begin
                        ctrl_o.set_pc           = z_i;
                        ctrl_o.pc_from_register = 1'b1;
                    end
                    OP_INC: begin
                        ctrl_o.reg_write      = 1'b1;
                        ctrl_o.alu_override_b = 1'b1;
                        ctrl_o.alu_set_flags  = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM_WAIT: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = last_wait_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle FSM sequencing the CPU datapath.
//   clock - rising-edge clock
//   reset - synchronous, active-high
//   bus   - control_sequencer_if.slave (run, instruction, Z in; strobes/status out)
// Parameters: MEM_LATENCY (1-7) read latency in cycles, CNT_W retired-counter width.
// Optional feature macro CTRL_SINGLE_STEP_EN: adds bus.step; the FSM parks in IDLE
// after every retirement and advances on a step rising edge (or run while step is high).
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    control_sequencer_if.slave   bus
);

    localparam logic [WAIT_W-1:0] FETCH_LAST = WAIT_W'(MEM_LATENCY);
    localparam logic [WAIT_W-1:0] MEMW_LAST  = WAIT_W'(MEM_LATENCY - 1);

    ctrl_state_t          state_q, state_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0]     retired_q, retired_d;
    logic                 illegal_q, illegal_d;
    logic                 retire_c;
    logic                 last_wait_c;
    logic                 advance_c;
    ctrl_state_t          after_retire_c;
    logic [OPCODE_W-1:0]  opcode_c;
    ctrl_signals_t        ctrl_c;
    logic                 unused_operand_bits;

    assign opcode_c            = bus.current_instruction[15:12];
    assign unused_operand_bits = ^bus.current_instruction[11:0];

    // FETCH spans MEM_LATENCY+1 cycles, MEM_WAIT spans MEM_LATENCY cycles.
    assign last_wait_c = (state_q == ST_FETCH) ? (wait_q == FETCH_LAST)
                                               : (wait_q == MEMW_LAST);

`ifdef CTRL_SINGLE_STEP_EN
    logic step_q;

    // Registered edge detect on the step button.
    always_ff @(posedge clock) begin
        if (reset) step_q <= 1'b0;
        else       step_q <= bus.step;
    end

    assign advance_c      = (bus.step & ~step_q) | (bus.run & bus.step);
    assign after_retire_c = ST_IDLE;
`else
    assign advance_c      = bus.run;
    assign after_retire_c = ST_FETCH;
`endif

    // State, wait counter, retired counter and sticky illegal flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        retire_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (advance_c) begin
                    state_d = ST_FETCH;
                    wait_d  = '0;
                end
            end
            ST_FETCH: begin
                if (last_wait_c) begin
                    state_d = ST_DECODE;
                    wait_d  = '0;
                end else begin
                    wait_d  = WAIT_W'(wait_q + WAIT_W'(1));
                end
            end
            ST_DECODE: begin
                if (opcode_c == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (is_illegal(opcode_c)) begin
                    // Undefined opcodes retire as a NOP.
                    illegal_d = 1'b1;
                    retire_c  = 1'b1;
                    state_d   = after_retire_c;
                    wait_d    = '0;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                wait_d = '0;
                if (opcode_c == OP_LOAD) begin
                    state_d = ST_MEM_WAIT;
                end else begin
                    retire_c = 1'b1;
                    state_d  = after_retire_c;
                end
            end
            ST_MEM_WAIT: begin
                if (last_wait_c) begin
                    retire_c = 1'b1;
                    state_d  = after_retire_c;
                    wait_d   = '0;
                end else begin
                    wait_d   = WAIT_W'(wait_q + WAIT_W'(1));
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
        retired_d = retire_c ? CNT_W'(retired_q + CNT_W'(1)) : retired_q;
    end

    opcode_decoder u_decoder (
        .state_i     (state_q),
        .opcode_i    (opcode_c),
        .z_i         (bus.Z_in),
        .last_wait_i (last_wait_c),
        .ctrl_o      (ctrl_c)
    );

    assign bus.fetch_instruction = ctrl_c.fetch_instruction;
    assign bus.reg_write         = ctrl_c.reg_write;
    assign bus.mem_to_reg        = ctrl_c.mem_to_reg;
    assign bus.mem_write         = ctrl_c.mem_write;
    assign bus.alu_override_imm  = ctrl_c.alu_override_imm;
    assign bus.alu_override_b    = ctrl_c.alu_override_b;
    assign bus.alu_set_flags     = ctrl_c.alu_set_flags;
    assign bus.set_pc            = ctrl_c.set_pc;
    assign bus.pc_from_register  = ctrl_c.pc_from_register;
    assign bus.halted            = (state_q == ST_HALT);
    assign bus.illegal_op        = illegal_q;
    assign bus.state_poke        = state_q;
    assign bus.retired           = retired_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed bench for control_sequencer.
// Three instances: d1 (latency 1), d2 (latency 2), d3 (latency 3, 2-bit retired counter
// so wrap is reachable). Observation vector = {state_poke, nine strobes}.
module tb_control_sequencer;

    localparam logic [8:0] S_FETCH = 9'b1_0000_0000;
    localparam logic [8:0] S_RW    = 9'b0_1000_0000;
    localparam logic [8:0] S_M2R   = 9'b0_0100_0000;
    localparam logic [8:0] S_MW    = 9'b0_0010_0000;
    localparam logic [8:0] S_IMM   = 9'b0_0001_0000;
    localparam logic [8:0] S_B     = 9'b0_0000_1000;
    localparam logic [8:0] S_FLG   = 9'b0_0000_0100;
    localparam logic [8:0] S_SPC   = 9'b0_0000_0010;
    localparam logic [8:0] S_PCR   = 9'b0_0000_0001;
    localparam logic [8:0] S_NONE  = 9'b0_0000_0000;

    logic clock = 1'b0;
    logic rst1, rst2, rst3;
    int   checks   = 0;
    int   failures = 0;
    int   exp_ret1 = 0;
    int   exp_ret2 = 0;
    int   exp_ret3 = 0;

    always #5 clock = ~clock;

    control_sequencer_if #(.CNT_W(16)) if1 ();
    control_sequencer_if #(.CNT_W(16)) if2 ();
    control_sequencer_if #(.CNT_W(2))  if3 ();

    control_sequencer #(.MEM_LATENCY(1), .CNT_W(16)) d1 (.clock(clock), .reset(rst1), .bus(if1.slave));
    control_sequencer #(.MEM_LATENCY(2), .CNT_W(16)) d2 (.clock(clock), .reset(rst2), .bus(if2.slave));
    control_sequencer #(.MEM_LATENCY(3), .CNT_W(2))  d3 (.clock(clock), .reset(rst3), .bus(if3.slave));

    logic [11:0] o1, o2, o3;
    assign o1 = {if1.state_poke, if1.fetch_instruction, if1.reg_write, if1.mem_to_reg, if1.mem_write,
                 if1.alu_override_imm, if1.alu_override_b, if1.alu_set_flags, if1.set_pc, if1.pc_from_register};
    assign o2 = {if2.state_poke, if2.fetch_instruction, if2.reg_write, if2.mem_to_reg, if2.mem_write,
                 if2.alu_override_imm, if2.alu_override_b, if2.alu_set_flags, if2.set_pc, if2.pc_from_register};
    assign o3 = {if3.state_poke, if3.fetch_instruction, if3.reg_write, if3.mem_to_reg, if3.mem_write,
                 if3.alu_override_imm, if3.alu_override_b, if3.alu_set_flags, if3.set_pc, if3.pc_from_register};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // d1 (latency 1) non-LOAD instruction, entered with F0 already sampled.
    task automatic instr1(input string tag, input logic [15:0] ins, input logic [8:0] ex, input logic z);
        if1.current_instruction = ins;
        if1.Z_in = z;
        tick(); chk({tag, "_f1"},  32'(o1), 32'({3'd1, S_FETCH | S_SPC}));
        tick(); chk({tag, "_dec"}, 32'(o1), 32'({3'd2, S_NONE}));
        tick(); chk({tag, "_exe"}, 32'(o1), 32'({3'd3, ex}));
        tick(); exp_ret1++;
        chk({tag, "_f0"},  32'(o1), 32'({3'd1, S_FETCH}));
        chk({tag, "_ret"}, 32'(if1.retired), 32'(exp_ret1));
    endtask

    // d2 (latency 2) non-LOAD instruction, entered with F0 already sampled.
    task automatic instr2(input string tag, input logic [15:0] ins, input logic [8:0] ex);
        if2.current_instruction = ins;
        tick(); chk({tag, "_f1"},  32'(o2), 32'({3'd1, S_FETCH}));
        tick(); chk({tag, "_f2"},  32'(o2), 32'({3'd1, S_FETCH | S_SPC}));
        tick(); chk({tag, "_dec"}, 32'(o2), 32'({3'd2, S_NONE}));
        tick(); chk({tag, "_exe"}, 32'(o2), 32'({3'd3, ex}));
        tick(); exp_ret2++;
        chk({tag, "_f0"},  32'(o2), 32'({3'd1, S_FETCH}));
        chk({tag, "_ret"}, 32'(if2.retired), 32'(exp_ret2));
    endtask

    initial begin
        rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        if1.run = 1'b1; if1.current_instruction = 16'h2130; if1.Z_in = 1'b0;
        if2.run = 1'b1; if2.current_instruction = 16'h0120; if2.Z_in = 1'b0;
        if3.run = 1'b1; if3.current_instruction = 16'h2130; if3.Z_in = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
        if1.step = 1'b0; if2.step = 1'b0; if3.step = 1'b0;
        if1.run = 1'b0;
        if1.current_instruction = 16'h0120;
        tick(); tick();
        rst1 = 1'b0;
        tick(); chk("ss_idle_norun", 32'(o1), 32'({3'd0, S_NONE}));
        if1.step = 1'b1;
        tick(); chk("ss_f0",  32'(o1), 32'({3'd1, S_FETCH}));
        tick(); chk("ss_f1",  32'(o1), 32'({3'd1, S_FETCH | S_SPC}));
        tick(); chk("ss_dec", 32'(o1), 32'({3'd2, S_NONE}));
        tick(); chk("ss_exe", 32'(o1), 32'({3'd3, S_RW | S_FLG}));
        tick(); chk("ss_park1", 32'(o1), 32'({3'd0, S_NONE}));
        chk("ss_ret1", 32'(if1.retired), 32'd1);
        tick(); chk("ss_held", 32'(o1), 32'({3'd0, S_NONE}));
        chk("ss_ret1_held", 32'(if1.retired), 32'd1);
        if1.run = 1'b1;
        tick(); chk("ss_run_step_f0", 32'(o1), 32'({3'd1, S_FETCH}));
        if1.run = 1'b0;
        tick(); tick(); tick(); tick();
        chk("ss_park2", 32'(o1), 32'({3'd0, S_NONE}));
        chk("ss_ret2", 32'(if1.retired), 32'd2);
        if1.step = 1'b0;
        tick(); chk("ss_low", 32'(o1), 32'({3'd0, S_NONE}));
        if1.step = 1'b1;
        tick(); chk("ss_edge_f0", 32'(o1), 32'({3'd1, S_FETCH}));
        tick(); tick(); tick(); tick();
        chk("ss_ret3", 32'(if1.retired), 32'd3);
`else
        // ---------------- d1: reset, LOAD, JZ, illegal, halt ----------------
        tick(); chk("d1_rst_a", 32'(o1), 32'({3'd0, S_NONE}));
        chk("d1_rst_ret", 32'(if1.retired), 32'd0);
        chk("d1_rst_flags", 32'({if1.halted, if1.illegal_op}), 32'd0);
        tick(); chk("d1_rst_b", 32'(o1), 32'({3'd0, S_NONE}));
        rst1 = 1'b0;
        chk("d1_rel", 32'(o1), 32'({3'd0, S_NONE}));
        tick(); chk("ld1_f0",  32'(o1), 32'({3'd1, S_FETCH}));
        tick(); chk("ld1_f1",  32'(o1), 32'({3'd1, S_FETCH | S_SPC}));
        tick(); chk("ld1_dec", 32'(o1), 32'({3'd2, S_NONE}));
        tick(); chk("ld1_exe", 32'(o1), 32'({3'd3, S_NONE}));
        tick(); chk("ld1_mw",  32'(o1), 32'({3'd4, S_M2R | S_RW}));
        chk("ld1_mw_ret", 32'(if1.retired), 32'd0);
        tick(); exp_ret1++;
        chk("ld1_f0n", 32'(o1), 32'({3'd1, S_FETCH}));
        chk("ld1_ret", 32'(if1.retired), 32'(exp_ret1));
        instr1("jz_z0", 16'h5200, S_PCR, 1'b0);
        instr1("jz_z1", 16'h5200, S_SPC | S_PCR, 1'b1);
        if1.Z_in = 1'b0;
        if1.current_instruction = 16'h9000;
        tick(); chk("ill_f1",  32'(o1), 32'({3'd1, S_FETCH | S_SPC}));
        tick(); chk("ill_dec", 32'(o1), 32'({3'd2, S_NONE}));
        chk("ill_pre", 32'(if1.illegal_op), 32'd0);
        tick(); exp_ret1++;
        chk("ill_f0",  32'(o1), 32'({3'd1, S_FETCH}));
        chk("ill_set", 32'(if1.illegal_op), 32'd1);
        chk("ill_ret", 32'(if1.retired), 32'(exp_ret1));
        instr1("alu_post_ill", 16'h0120, S_RW | S_FLG, 1'b0);
        chk("ill_sticky", 32'(if1.illegal_op), 32'd1);
        if1.current_instruction = 16'h7000;
        tick(); chk("hlt_f1",  32'(o1), 32'({3'd1, S_FETCH | S_SPC}));
        tick(); chk("hlt_dec", 32'(o1), 32'({3'd2, S_NONE}));
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hlt_state",  32'(o1), 32'({3'd5, S_NONE}));
            chk("hlt_halted", 32'(if1.halted), 32'd1);
            chk("hlt_ret",    32'(if1.retired), 32'(exp_ret1));
        end
        rst1 = 1'b1;
        tick(); chk("hlt_rst", 32'(o1), 32'({3'd0, S_NONE}));
        chk("hlt_rst_flags", 32'({if1.halted, if1.illegal_op}), 32'd0);
        chk("hlt_rst_ret", 32'(if1.retired), 32'd0);
        rst1 = 1'b0; if1.run = 1'b0;
        tick(); tick();
        chk("idle_norun", 32'(o1), 32'({3'd0, S_NONE}));

        // ---------------- d2: reset release timing, EXEC strobes, mid-instruction reset ----
        tick(); chk("d2_rst_a", 32'(o2), 32'({3'd0, S_NONE}));
        tick(); chk("d2_rst_b", 32'(o2), 32'({3'd0, S_NONE}));
        tick(); chk("d2_rst_c", 32'(o2), 32'({3'd0, S_NONE}));
        chk("d2_rst_ret", 32'(if2.retired), 32'd0);
        rst2 = 1'b0;
        chk("d2_rel_idle", 32'(o2), 32'({3'd0, S_NONE}));
        tick(); chk("d2_rel_f0", 32'(o2), 32'({3'd1, S_FETCH}));
        instr2("alu",   16'h0120, S_RW | S_FLG);
        instr2("ldi",   16'h1000, S_RW | S_IMM);
        instr2("store", 16'h3000, S_MW);
        instr2("jmp",   16'h4000, S_SPC | S_PCR);
        if2.current_instruction = 16'h6000;
        tick(); tick(); tick();
        chk("inc_dec", 32'(o2), 32'({3'd2, S_NONE}));
        tick(); chk("inc_exe", 32'(o2), 32'({3'd3, S_RW | S_B | S_FLG}));
        rst2 = 1'b1;
        tick(); chk("abort", 32'(o2), 32'({3'd0, S_NONE}));
        chk("abort_ret", 32'(if2.retired), 32'd0);
        rst2 = 1'b0; if2.run = 1'b0;

        // ---------------- d3: latency-3 LOAD and retired wrap (2-bit counter) ----------------
        rst3 = 1'b0;
        chk("d3_rel", 32'(o3), 32'({3'd0, S_NONE}));
        tick(); chk("ld3_f0", 32'(o3), 32'({3'd1, S_FETCH}));
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("ld3_fetch", 32'(o3), 32'({3'd1, (k == 3) ? (S_FETCH | S_SPC) : S_FETCH}));
        end
        tick(); chk("ld3_dec", 32'(o3), 32'({3'd2, S_NONE}));
        tick(); chk("ld3_exe", 32'(o3), 32'({3'd3, S_NONE}));
        tick(); chk("ld3_mw0", 32'(o3), 32'({3'd4, S_M2R}));
        tick(); chk("ld3_mw1", 32'(o3), 32'({3'd4, S_M2R}));
        tick(); chk("ld3_mw2", 32'(o3), 32'({3'd4, S_M2R | S_RW}));
        chk("ld3_mw_ret", 32'(if3.retired), 32'd0);
        tick(); exp_ret3 = (exp_ret3 + 1) % 4;
        chk("ld3_f0n", 32'(o3), 32'({3'd1, S_FETCH}));
        chk("ld3_ret", 32'(if3.retired), 32'(exp_ret3));
        if3.current_instruction = 16'h0120;
        for (int n = 0; n < 3; n++) begin
            tick(); tick(); tick();
            chk("wr_f3",  32'(o3), 32'({3'd1, S_FETCH | S_SPC}));
            tick(); tick();
            chk("wr_exe", 32'(o3), 32'({3'd3, S_RW | S_FLG}));
            tick(); exp_ret3 = (exp_ret3 + 1) % 4;
            chk("wr_ret", 32'(if3.retired), 32'(exp_ret3));
        end
        chk("wrap_zero", 32'(if3.retired), 32'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
